// File: rtl/wb_pipe_master.sv
// Wishbone B4 pipelined master: client requests in, issue-ordered responses out.
// A we-tag FIFO keeps responses in order; err/rty/timeout flushes every in-flight tag as an error.
module wb_pipe_master #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 22,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_we_i,
  input  logic [ADDR_WIDTH-1:0]                req_addr_i,
  input  logic [DATA_WIDTH/8-1:0]              req_sel_i,
  input  logic [DATA_WIDTH-1:0]                req_wdata_i,
  output logic                                 resp_valid_o,
  output logic                                 resp_we_o,
  output logic [DATA_WIDTH-1:0]                resp_rdata_o,
  output logic                                 resp_err_o,
  output logic                                 cyc_o,
  output logic                                 stb_o,
  output logic                                 we_o,
  output logic [ADDR_WIDTH-1:0]                addr_o,
  output logic [DATA_WIDTH/8-1:0]              sel_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  input  logic [DATA_WIDTH-1:0]                rdata_i,
  input  logic                                 ack_i,
  input  logic                                 err_i,
  input  logic                                 rty_i,
  input  logic                                 stall_i,
  output logic                                 busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ABORT  = 2'd2;

  localparam logic [CW:0]   MAX_C   = (CW + 1)'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]                 state_q, state_d;
  logic                       stb_q, stb_d;
  logic                       we_q, we_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [SW-1:0]              sel_q, sel_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       resp_we_q, resp_we_d;
  logic                       resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0]      resp_rdata_q, resp_rdata_d;

  logic accept, issue, slv_ok, slv_err, flush, pop, timeout, cnt_nz, tag_out, active;

  assign active  = (state_q == ST_ACTIVE);
  assign cnt_nz  = (cnt_q != '0);
  assign tag_out = tag_q[rd_ptr_q];

  assign req_ready_o = rstn_i && (state_q != ST_ABORT) && !(stb_q && stall_i) &&
                       (({1'b0, cnt_q} + {{CW{1'b0}}, stb_q}) < MAX_C);

  assign accept  = req_valid_i && req_ready_o;
  assign issue   = active && stb_q && !stall_i;
  // Slave responses with nothing in flight are ignored entirely.
  assign slv_err = active && cnt_nz && (err_i || rty_i);
  assign slv_ok  = active && cnt_nz && ack_i && !err_i && !rty_i;
  assign flush   = (state_q == ST_ABORT) && cnt_nz;
  assign pop     = slv_ok || slv_err || flush;
  assign timeout = active && cnt_nz && !issue && !slv_ok && !slv_err && (timer_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    stb_d        = stb_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    if (issue) tag_d[wr_ptr_q] = we_q;
    wr_ptr_d = wr_ptr_q + PW'(issue);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(issue) - CW'(pop);

    if (pop) begin
      resp_valid_d = 1'b1;
      resp_we_d    = tag_out;
      resp_err_d   = !slv_ok;
      resp_rdata_d = (slv_ok && !tag_out) ? rdata_i : '0;
    end

    if (!active || !cnt_nz || issue || slv_ok || slv_err) timer_d = '0;
    else                                                  timer_d = timer_q + 1'b1;

    if (issue) stb_d = 1'b0;
    if (accept) begin
      stb_d   = 1'b1;
      we_d    = req_we_i;
      addr_d  = req_addr_i;
      sel_d   = req_sel_i;
      wdata_d = req_wdata_i;
    end

    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (slv_err || timeout) begin
          // Any request still waiting on the bus is dropped silently.
          state_d = ST_ABORT;
          stb_d   = 1'b0;
        end else if (!cnt_nz && !stb_q && !accept) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: if (cnt_q <= CW'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign stb_o         = stb_q;
  assign we_o          = we_q;
  assign addr_o        = addr_q;
  assign sel_o         = sel_q;
  assign wdata_o       = wdata_q;
  assign cyc_o         = active && (stb_q || cnt_nz);
  assign busy_o        = (state_q != ST_IDLE) || stb_q;
  assign outstanding_o = cnt_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_we_o     = resp_we_q;
  assign resp_err_o    = resp_err_q;
  assign resp_rdata_o  = resp_rdata_q;

endmodule

// File: tb/tb_wb_pipe_master.sv
// Bench for wb_pipe_master: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_pipe_master;
  localparam int DW = 128;
  localparam int AW = 22;
  localparam int MO = 8;
  localparam int TO = 64;
  localparam int SW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rstn_i = 1'b0;
  logic req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [SW-1:0] req_sel_i;
  logic [DW-1:0] req_wdata_i;
  logic resp_valid_o, resp_we_o, resp_err_o;
  logic [DW-1:0] resp_rdata_o;
  logic cyc_o, stb_o, we_o;
  logic [AW-1:0] addr_o;
  logic [SW-1:0] sel_o;
  logic [DW-1:0] wdata_o, rdata_i;
  logic ack_i, err_i, rty_i, stall_i, busy_o;
  logic [CW-1:0] outstanding_o;

  always #5 clk = ~clk;

  wb_pipe_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o), .resp_rdata_o(resp_rdata_o),
    .resp_err_o(resp_err_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
    .sel_o(sel_o), .wdata_o(wdata_o), .rdata_i(rdata_i), .ack_i(ack_i), .err_i(err_i),
    .rty_i(rty_i), .stall_i(stall_i), .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  int errors = 0;
  int checks = 0;
  int issue_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending (un-issued) request, a queue of issued we tags,
  // a mode (0 idle, 1 active, 2 abort) and a count of quiet cycles.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
  } req_t;

  bit            m_pend;
  req_t          m_req;
  bit            m_tags[$];
  int            m_mode;
  int            m_quiet;
  bit            e_rv, e_rwe, e_rerr;
  logic [DW-1:0] e_rdata;
  bit            m_ready, m_acc, m_iss, m_rev, m_iserr, m_was_empty;
  int            m_sz0;

  always @(negedge clk) begin
    if (!rstn_i) begin
      m_pend = 0; m_tags.delete(); m_mode = 0; m_quiet = 0;
      e_rv = 0; e_rwe = 0; e_rerr = 0; e_rdata = '0;
      chk("rst_ctrl", {cyc_o, stb_o, we_o, busy_o, resp_valid_o, resp_we_o, resp_err_o, req_ready_o}, '0);
      chk("rst_bus", {addr_o, sel_o, outstanding_o}, '0);
      chk("rst_wdata", wdata_o, '0);
      chk("rst_rdata", resp_rdata_o, '0);
    end else begin
      m_sz0   = m_tags.size();
      m_ready = (m_mode != 2) && !(m_pend && stall_i) && (m_sz0 + int'(m_pend) < MO);
      chk("stb_o", stb_o, m_pend);
      if (m_pend) begin
        chk("we_o", we_o, m_req.we);
        chk("addr_o", addr_o, m_req.addr);
        chk("sel_o", sel_o, m_req.sel);
        chk("wdata_o", wdata_o, m_req.wdata);
      end
      chk("cyc_o", cyc_o, (m_mode == 1) && (m_pend || m_sz0 > 0));
      chk("outstanding_o", outstanding_o, m_sz0);
      chk("busy_o", busy_o, (m_mode != 0) || m_pend);
      chk("req_ready_o", req_ready_o, m_ready);
      chk("resp_valid_o", resp_valid_o, e_rv);
      if (e_rv) begin
        chk("resp_we_o", resp_we_o, e_rwe);
        chk("resp_err_o", resp_err_o, e_rerr);
        chk("resp_rdata_o", resp_rdata_o, e_rdata);
      end
      if (stb_o && !stall_i) issue_cnt++;

      m_acc = req_valid_i && m_ready;
      m_iss = m_pend && !stall_i && (m_mode == 1);
      e_rv = 0; e_rwe = 0; e_rerr = 0; e_rdata = '0;
      case (m_mode)
        0: if (m_acc) begin
          m_pend = 1; m_req = '{req_we_i, req_addr_i, req_sel_i, req_wdata_i}; m_mode = 1;
        end
        1: begin
          m_was_empty = (m_sz0 == 0) && !m_pend;
          m_iserr = err_i || rty_i;
          m_rev = (m_sz0 > 0) && (ack_i || m_iserr);
          if (m_rev) begin
            e_rv = 1; e_rwe = m_tags.pop_front(); e_rerr = m_iserr;
            e_rdata = (m_iserr || e_rwe) ? '0 : rdata_i;
          end
          if (m_iss) m_tags.push_back(m_req.we);
          if (m_iss || m_rev || m_sz0 == 0) m_quiet = 0;
          else m_quiet++;
          if ((m_rev && m_iserr) || m_quiet == TO) begin
            m_mode = 2; m_pend = 0; m_quiet = 0;
          end else begin
            if (m_iss) m_pend = 0;
            if (m_acc) begin
              m_pend = 1; m_req = '{req_we_i, req_addr_i, req_sel_i, req_wdata_i};
            end
            if (m_was_empty && !m_acc) m_mode = 0;
          end
        end
        default: begin
          if (m_tags.size() > 0) begin
            e_rv = 1; e_rerr = 1; e_rwe = m_tags.pop_front();
          end
          if (m_tags.size() == 0) m_mode = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [SW-1:0] s,
                      input logic [DW-1:0] d);
    int n = 0;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_sel_i = s; req_wdata_i = d;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("send_ready_budget", (n < 100), 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_ack(input logic [DW-1:0] d);
    ack_i = 1'b1; rdata_i = d;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic wait_resp(output int idx, input int budget);
    idx = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        idx = i;
        break;
      end
    end
  endtask

  int idx, ic0, nresp;
  logic [DW-1:0] pat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_sel_i = '0; req_wdata_i = '0;
    rdata_i = '0; ack_i = 0; err_i = 0; rty_i = 0; stall_i = 0;
    repeat (3) @(posedge clk);
    #1 rstn_i = 1'b1;
    @(negedge clk);
    chk("ready_after_release", req_ready_o, 1'b1);

    // Single read, ack three cycles after issue.
    tick();
    send(1'b0, 22'h10, '1, '0);
    req_valid_i = 1'b0;
    repeat (3) tick();
    pulse_ack(128'hA5);
    wait_resp(idx, 10);
    chk("rd_resp_latency", idx, 0);
    chk("rd_resp_rdata", resp_rdata_o, 128'hA5);
    chk("rd_resp_we", resp_we_o, 1'b0);
    chk("rd_resp_err", resp_err_o, 1'b0);
    @(negedge clk);
    chk("rd_cyc_low", cyc_o, 1'b0);

    // Eight back-to-back writes with no acks fill the window.
    tick();
    ic0 = issue_cnt;
    for (int i = 0; i < 8; i++) send(1'b1, AW'(32'h100 + i), '1, DW'(i + 1));
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_outstanding", outstanding_o, 8);
    chk("full_ready_low", req_ready_o, 1'b0);
    chk("full_issue_count", issue_cnt - ic0, 8);
    tick();
    pulse_ack({4{32'hDEAD_BEEF}});
    @(negedge clk);
    chk("ready_after_one_ack", req_ready_o, 1'b1);
    tick();
    ack_i = 1'b1;
    repeat (7) tick();
    ack_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_outstanding", outstanding_o, 0);

    // Stalled write holds its bus fields, then issues exactly once.
    tick();
    stall_i = 1'b1;
    pat = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    ic0 = issue_cnt;
    send(1'b1, 22'h2A, 16'h00F0, pat);
    req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_addr", addr_o, 22'h2A);
      chk("stall_sel", sel_o, 16'h00F0);
      chk("stall_wdata", wdata_o, pat);
    end
    tick();
    stall_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("stall_single_issue", issue_cnt - ic0, 1);
    tick();
    pulse_ack('0);
    repeat (3) @(negedge clk);

    // Error on the first of three reads flushes all three as errors.
    tick();
    for (int i = 0; i < 3; i++) send(1'b0, AW'(32'h40 + i), '1, '0);
    req_valid_i = 1'b0;
    tick();
    err_i = 1'b1;
    tick();
    err_i = 1'b0;
    @(negedge clk);
    chk("err_cyc_low", cyc_o, 1'b0);
    nresp = int'(resp_valid_o && resp_err_o);
    repeat (2) begin
      @(negedge clk);
      nresp += int'(resp_valid_o && resp_err_o);
    end
    chk("err_resp_count", nresp, 3);
    @(negedge clk);
    chk("err_outstanding", outstanding_o, 0);
    chk("err_idle", busy_o, 1'b0);

    // Timeout on an unacknowledged read, then a spurious ack while idle.
    tick();
    send(1'b0, 22'h55, '1, '0);
    req_valid_i = 1'b0;
    wait_resp(idx, TO + 20);
    chk("timeout_latency", idx, TO + 2);
    chk("timeout_err", resp_err_o, 1'b1);
    repeat (2) @(negedge clk);
    chk("timeout_idle", busy_o, 1'b0);
    tick();
    pulse_ack(128'h77);
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      nresp += int'(resp_valid_o);
    end
    chk("spurious_ack_no_resp", nresp, 0);

    // Reset with four writes in flight.
    tick();
    for (int i = 0; i < 4; i++) send(1'b1, AW'(32'h200 + i), '1, DW'(32'hA0 + i));
    req_valid_i = 1'b0;
    tick();
    @(negedge clk);
    chk("pre_reset_outstanding", outstanding_o, 4);
    tick();
    rstn_i = 1'b0;
    #1;
    chk("async_rst_ctrl", {cyc_o, stb_o, busy_o, req_ready_o, resp_valid_o}, '0);
    chk("async_rst_outstanding", outstanding_o, 0);
    repeat (2) tick();
    rstn_i = 1'b1;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    nresp = 0;
    repeat (4) begin
      @(negedge clk);
      nresp += int'(resp_valid_o);
    end
    chk("post_reset_no_resp", nresp, 0);
    tick();
    send(1'b0, 22'h33, '1, '0);
    req_valid_i = 1'b0;
    tick();
    pulse_ack(128'hC0FFEE);
    wait_resp(idx, 10);
    chk("post_reset_latency", idx, 0);
    chk("post_reset_rdata", resp_rdata_o, 128'hC0FFEE);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
